// File: rtl/wash_pkg.sv
// Shared definitions for the washer cycle scheduler: phase encoding,
// mode-mask bit positions and small combinational helpers.
package wash_pkg;

  // Phase codes as seen by the display and indicator blocks
  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_LOCK  = 3'd1;
  localparam logic [2:0] PH_WASH  = 3'd2;
  localparam logic [2:0] PH_RINSE = 3'd3;
  localparam logic [2:0] PH_SPIN  = 3'd4;
  localparam logic [2:0] PH_PAUSE = 3'd5;
  localparam logic [2:0] PH_DONE  = 3'd6;

  // Bit positions inside the mode enable mask
  localparam int unsigned MODE_WASH  = 0;
  localparam int unsigned MODE_RINSE = 1;
  localparam int unsigned MODE_SPIN  = 2;

  typedef enum logic [2:0] {
    S_IDLE  = PH_IDLE,
    S_LOCK  = PH_LOCK,
    S_WASH  = PH_WASH,
    S_RINSE = PH_RINSE,
    S_SPIN  = PH_SPIN,
    S_PAUSE = PH_PAUSE,
    S_DONE  = PH_DONE
  } state_e;

  // Water level limited to the legal 1..5 range
  function automatic logic [2:0] clamp_wat(input logic [2:0] w);
    logic [2:0] r;
    if (w == 3'd0) begin
      r = 3'd1;
    end else if (w > 3'd5) begin
      r = 3'd5;
    end else begin
      r = w;
    end
    return r;
  endfunction

  // Next enabled working phase after cur (LOCK starts the search at WASH)
  function automatic state_e next_phase(input logic [2:0] m, input state_e cur);
    state_e r;
    case (cur)
      S_LOCK: begin
        if (m[MODE_WASH])       r = S_WASH;
        else if (m[MODE_RINSE]) r = S_RINSE;
        else if (m[MODE_SPIN])  r = S_SPIN;
        else                    r = S_DONE;
      end
      S_WASH: begin
        if (m[MODE_RINSE])      r = S_RINSE;
        else if (m[MODE_SPIN])  r = S_SPIN;
        else                    r = S_DONE;
      end
      S_RINSE: begin
        if (m[MODE_SPIN])       r = S_SPIN;
        else                    r = S_DONE;
      end
      default: r = S_DONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Loadable down-counter paced by the time-unit tick. Holds its value when
// not enabled; flags the tick that takes it from 1 to 0.
module wash_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats load, load beats a tick, otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = en_i && (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/wash_sequencer.sv
// Washer cycle scheduler: LOCK -> WASH -> RINSE -> SPIN -> DONE with pause,
// paced by the shared tick. One down-counter is reused for lock, phase and
// buzzer durations; rem tracks the total ticks left over all enabled phases.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned WSH_UNITS = 9,
  parameter int unsigned RNS_UNITS = 6,
  parameter int unsigned SPN_UNITS = 3,
  parameter int unsigned LCK_TICKS = 2,
  parameter int unsigned END_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr,
  input  logic       tick,
  input  logic       run_p,
  input  logic [2:0] mode,
  input  logic [2:0] wat,
  output logic [2:0] phase,
  output logic [7:0] rem,
  output logic       lock,
  output logic       busy,
  output logic       done_p,
  output logic       buzz
);

  localparam logic [7:0] WSH_L = 8'(WSH_UNITS);
  localparam logic [7:0] RNS_L = 8'(RNS_UNITS);
  localparam logic [7:0] SPN_L = 8'(SPN_UNITS);
  localparam logic [7:0] LCK_L = 8'(LCK_TICKS);
  localparam logic [7:0] END_L = 8'(END_TICKS);

  state_e     state_q, state_d;
  state_e     saved_q, saved_d;
  logic [2:0] mode_q,  mode_d;
  logic [2:0] wat_q,   wat_d;
  logic [7:0] rem_q,   rem_d;
  logic       lock_q,  lock_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       buzz_q,  buzz_d;

  logic       ld_s;
  logic [7:0] ld_val_s;
  logic       en_s;
  logic       zero_s;
  logic [7:0] cnt_s;
  state_e     nxt_s;
  logic [2:0] wat_in_s;

  // Ticks for one phase (DONE yields the buzzer length)
  function automatic logic [7:0] phase_len(input state_e p, input logic [2:0] w);
    logic [7:0] r;
    case (p)
      S_WASH:  r = WSH_L + {5'd0, w};
      S_RINSE: r = RNS_L + {5'd0, w};
      S_SPIN:  r = SPN_L;
      S_DONE:  r = END_L;
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  // Sum of all enabled phase durations
  function automatic logic [7:0] total_len(input logic [2:0] m, input logic [2:0] w);
    logic [7:0] r;
    r = 8'd0;
    if (m[MODE_WASH])  r = r + phase_len(S_WASH, w);
    else               r = r;
    if (m[MODE_RINSE]) r = r + phase_len(S_RINSE, w);
    else               r = r;
    if (m[MODE_SPIN])  r = r + phase_len(S_SPIN, w);
    else               r = r;
    return r;
  endfunction

  // Timer counts only in timed states; a drained counter never underflows
  always_comb begin
    en_s = 1'b0;
    case (state_q)
      S_LOCK, S_WASH, S_RINSE, S_SPIN, S_DONE: en_s = tick && (cnt_s != 8'd0);
      default:                                 en_s = 1'b0;
    endcase
  end

  wash_phase_timer #(.W(8)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (~pwr),
    .load_i     (ld_s),
    .load_val_i (ld_val_s),
    .en_i       (en_s),
    .cnt_o      (cnt_s),
    .zero_o     (zero_s)
  );

  // Next-state, counter load and output decisions
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    mode_d   = mode_q;
    wat_d    = wat_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    buzz_d   = buzz_q;
    ld_s     = 1'b0;
    ld_val_s = 8'd0;
    nxt_s    = next_phase(mode_q, state_q);
    wat_in_s = clamp_wat(wat);

    if (!pwr) begin
      state_d = S_IDLE;
      saved_d = S_IDLE;
      mode_d  = 3'd0;
      wat_d   = 3'd0;
      rem_d   = 8'd0;
      buzz_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_p && (mode != 3'd0)) begin
            state_d  = S_LOCK;
            mode_d   = mode;
            wat_d    = wat_in_s;
            rem_d    = total_len(mode, wat_in_s);
            ld_s     = 1'b1;
            ld_val_s = LCK_L;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOCK: begin
          if (zero_s) begin
            state_d  = nxt_s;
            ld_s     = 1'b1;
            ld_val_s = phase_len(nxt_s, wat_q);
          end else begin
            state_d = S_LOCK;
          end
        end
        S_WASH, S_RINSE, S_SPIN: begin
          if (en_s) begin
            rem_d = rem_q - 8'd1;
          end else begin
            rem_d = rem_q;
          end
          // Final tick of a phase wins over a simultaneous pause press
          if (zero_s) begin
            state_d  = nxt_s;
            ld_s     = 1'b1;
            ld_val_s = phase_len(nxt_s, wat_q);
            if (nxt_s == S_DONE) begin
              done_d = 1'b1;
              buzz_d = 1'b1;
            end else begin
              done_d = 1'b0;
            end
          end else if (run_p) begin
            state_d = S_PAUSE;
            saved_d = state_q;
          end else begin
            state_d = state_q;
          end
        end
        S_PAUSE: begin
          if (run_p) begin
            state_d = saved_q;
          end else begin
            state_d = S_PAUSE;
          end
        end
        S_DONE: begin
          if (zero_s) begin
            state_d = S_IDLE;
            buzz_d  = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          buzz_d  = 1'b0;
        end
      endcase
    end

    lock_d = (state_d == S_LOCK) || (state_d == S_WASH) || (state_d == S_RINSE) ||
             (state_d == S_SPIN) || (state_d == S_PAUSE);
    busy_d = (state_d != S_IDLE);
  end

  // State and registered output bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      saved_q <= S_IDLE;
      mode_q  <= 3'd0;
      wat_q   <= 3'd0;
      rem_q   <= 8'd0;
      lock_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      mode_q  <= mode_d;
      wat_q   <= wat_d;
      rem_q   <= rem_d;
      lock_q  <= lock_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      buzz_q  <= buzz_d;
    end
  end

  assign phase  = state_q;
  assign rem    = rem_q;
  assign lock   = lock_q;
  assign busy   = busy_q;
  assign done_p = done_q;
  assign buzz   = buzz_q;

endmodule
